// File: rtl/mult_mac_acc.sv
// Multiply-accumulate controller around an external pipelined 16x16 multiplier.
// A tag pipe follows each issued op, and products are summed into a 40-bit accumulator.
`timescale 1ns/1ps

module mult_mac_acc #(
    parameter int unsigned MULT_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_multa_ns,
    input  logic        i_multb_ns,
    input  logic [15:0] i_multa,
    input  logic [15:0] i_multb,
    input  logic        i_last,
    output logic        o_multa_ns,
    output logic        o_multb_ns,
    output logic [15:0] o_multa,
    output logic [15:0] o_multb,
    input  logic [31:0] i_product,
    output logic        o_acc_valid,
    input  logic        i_acc_ready,
    output logic [39:0] o_acc,
    output logic [7:0]  o_acc_cnt,
    output logic        o_acc_ovf
);

    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TAG_D  = MULT_LAT + 1;

    logic [TAG_D-1:0] r_tag_v;
    logic [TAG_D-1:0] r_tag_last;
    logic [TAG_D-1:0] r_tag_sext;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_blk;
    logic             w_last_in_flight;
    logic             w_retire;
    logic             w_retire_last;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf_now;
    logic [CNT_W-1:0] w_cnt_next;

    // A last op may only issue when the result slot is guaranteed free at its retire.
    assign w_last_in_flight = |(r_tag_v & r_tag_last);
    assign w_blk            = w_last_in_flight | (o_acc_valid & ~i_acc_ready);
    assign o_ready          = i_rstn & ~(i_valid & i_last & w_blk);
    assign w_accept         = i_valid & o_ready;

    assign w_retire      = r_tag_v[TAG_D-1];
    assign w_retire_last = w_retire & r_tag_last[TAG_D-1];

    assign w_ext      = r_tag_sext[TAG_D-1] ? {{EXT_W{i_product[PROD_W-1]}}, i_product}
                                            : {EXT_W'(0), i_product};
    assign w_sum      = r_acc + w_ext;
    assign w_ovf_now  = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) & (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    // Operand issue registers hold their value between accepts.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_multa    <= '0;
            o_multb    <= '0;
            o_multa_ns <= 1'b0;
            o_multb_ns <= 1'b0;
        end else if (w_accept) begin
            o_multa    <= i_multa;
            o_multb    <= i_multb;
            o_multa_ns <= i_multa_ns;
            o_multb_ns <= i_multb_ns;
        end
    end

    // Tag pipe: index 0 is the newest entry, TAG_D-1 pairs with i_product.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_tag_v    <= '0;
            r_tag_last <= '0;
            r_tag_sext <= '0;
        end else begin
            r_tag_v    <= {r_tag_v[TAG_D-2:0],    w_accept};
            r_tag_last <= {r_tag_last[TAG_D-2:0], w_accept & i_last};
            r_tag_sext <= {r_tag_sext[TAG_D-2:0], w_accept & (i_multa_ns | i_multb_ns)};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_retire_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_retire) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_next;
            r_ovf <= r_ovf | w_ovf_now;
        end
    end

    // Single-entry result slot; a same-cycle reload wins over the drain.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_acc_valid <= 1'b0;
            o_acc       <= '0;
            o_acc_cnt   <= '0;
            o_acc_ovf   <= 1'b0;
        end else if (w_retire_last) begin
            o_acc_valid <= 1'b1;
            o_acc       <= w_sum;
            o_acc_cnt   <= w_cnt_next;
            o_acc_ovf   <= r_ovf | w_ovf_now;
        end else if (i_acc_ready) begin
            o_acc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_mac_acc.sv
// Directed bench for mult_mac_acc with a behavioural MULT_LAT-stage multiplier model.
`timescale 1ns/1ps

module tb_mult_mac_acc;

    localparam int unsigned MULT_LAT = 2;

    logic        clk;
    logic        rstn;
    logic        i_valid;
    logic        o_ready;
    logic        i_multa_ns;
    logic        i_multb_ns;
    logic [15:0] i_multa;
    logic [15:0] i_multb;
    logic        i_last;
    logic        o_multa_ns;
    logic        o_multb_ns;
    logic [15:0] o_multa;
    logic [15:0] o_multb;
    logic [31:0] i_product;
    logic        o_acc_valid;
    logic        i_acc_ready;
    logic [39:0] o_acc;
    logic [7:0]  o_acc_cnt;
    logic        o_acc_ovf;

    mult_mac_acc #(.MULT_LAT(MULT_LAT)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_multa_ns  (i_multa_ns),
        .i_multb_ns  (i_multb_ns),
        .i_multa     (i_multa),
        .i_multb     (i_multb),
        .i_last      (i_last),
        .o_multa_ns  (o_multa_ns),
        .o_multb_ns  (o_multb_ns),
        .o_multa     (o_multa),
        .o_multb     (o_multb),
        .i_product   (i_product),
        .o_acc_valid (o_acc_valid),
        .i_acc_ready (i_acc_ready),
        .o_acc       (o_acc),
        .o_acc_cnt   (o_acc_cnt),
        .o_acc_ovf   (o_acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mul_model(input logic ans, input logic bns,
                                              input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] ea;
        logic signed [16:0] eb;
        logic signed [33:0] p;
        ea = {ans & a[15], a};
        eb = {bns & b[15], b};
        p  = ea * eb;
        return p[31:0];
    endfunction

    logic [31:0] pp [MULT_LAT];
    always @(posedge clk) begin
        pp[0] <= mul_model(o_multa_ns, o_multb_ns, o_multa, o_multb);
        for (int i = 1; i < int'(MULT_LAT); i++) pp[i] <= pp[i-1];
    end
    assign i_product = pp[MULT_LAT-1];

    typedef struct {
        logic [39:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
        int          cyc;
    } res_t;

    res_t res_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rstn && o_acc_valid && i_acc_ready)
            res_q.push_back('{o_acc, o_acc_cnt, o_acc_ovf, cyc});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one op from posedge+1 until accepted; returns the accept cycle.
    task automatic issue(input logic ans, input logic bns, input logic [15:0] a,
                         input logic [15:0] b, input logic last, output int acc_cyc);
        bit got;
        i_valid = 1'b1; i_multa_ns = ans; i_multb_ns = bns;
        i_multa = a; i_multb = b; i_last = last;
        acc_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            got = o_ready;
            if (got) acc_cyc = cyc;
            @(posedge clk); #1;
            if (got) break;
        end
        i_valid = 1'b0; i_last = 1'b0;
        if (acc_cyc < 0) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=no_accept expected=accept");
        end
    endtask

    task automatic wait_result(output res_t r, output bit ok);
        ok = 1'b0;
        r  = '{40'd0, 8'd0, 1'b0, 0};
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (res_q.size() > 0) break;
        end
        #1;
        if (res_q.size() > 0) begin
            r  = res_q.pop_front();
            ok = 1'b1;
        end else begin
            checks++; errors++;
            $display("FAIL result_timeout actual=none expected=result");
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_acc_valid) begin seen = 1'b1; break; end
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    typedef struct {
        logic        ans;
        logic        bns;
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
        logic        chk_lat;
        logic [39:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ac;
        res_t r;
        bit   ok;

        vecs[0] = '{1'b0, 1'b0, 16'd3,     16'd4,     1'b0, 1'b0, 40'd0,            8'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'd5,     16'd6,     1'b0, 1'b0, 40'd0,            8'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'd7,     16'd8,     1'b0, 1'b0, 40'd0,            8'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'd2,     16'd2,     1'b1, 1'b1, 40'd102,          8'd4, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF,  16'hFFFF,  1'b0, 1'b0, 40'd0,            8'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFE,  16'h8000,  1'b1, 1'b0, 40'hFF_FFFF_0001, 8'd2, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 40'h00_FFFE_0001, 8'd1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'hFFFD,  16'h0005,  1'b1, 1'b0, 40'hFF_FFFF_FFF1, 8'd1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h8000,  16'hFFFF,  1'b1, 1'b0, 40'hFF_FFFF_8000, 8'd1, 1'b0};

        rstn = 1'b0; i_valid = 1'b1; i_last = 1'b1; i_acc_ready = 1'b1;
        i_multa_ns = 1'b0; i_multb_ns = 1'b0; i_multa = 16'h1234; i_multb = 16'h5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   64'(o_ready),     64'd0);
        chk("rst_valid",   64'(o_acc_valid), 64'd0);
        chk("rst_acc",     64'(o_acc),       64'd0);
        chk("rst_cnt",     64'(o_acc_cnt),   64'd0);
        chk("rst_ovf",     64'(o_acc_ovf),   64'd0);
        chk("rst_mult",    64'({o_multa, o_multb, o_multa_ns, o_multb_ns}), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1; i_valid = 1'b0; i_last = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].ans, vecs[i].bns, vecs[i].a, vecs[i].b, vecs[i].last, ac);
            if (vecs[i].last) begin
                wait_result(r, ok);
                if (ok) begin
                    chk($sformatf("vec%0d_acc", i), 64'(r.acc), 64'(vecs[i].acc));
                    chk($sformatf("vec%0d_cnt", i), 64'(r.cnt), 64'(vecs[i].cnt));
                    chk($sformatf("vec%0d_ovf", i), 64'(r.ovf), 64'(vecs[i].ovf));
                    if (vecs[i].chk_lat)
                        chk($sformatf("vec%0d_lat", i), 64'(r.cyc - ac), 64'(MULT_LAT + 2));
                end
            end
        end

        // Backpressure: slot full blocks last ops, non-last still flow, one-cycle drain.
        i_acc_ready = 1'b0;
        issue(1'b0, 1'b0, 16'd3, 16'd5, 1'b1, ac);
        wait_valid("bp_first_valid");
        chk("bp_first_acc", 64'(o_acc), 64'd15);
        chk("bp_first_cnt", 64'(o_acc_cnt), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b1; i_last = 1'b1; i_multa = 16'd2; i_multb = 16'd7;
        repeat (3) begin
            @(negedge clk);
            chk("bp_last_blocked", 64'(o_ready), 64'd0);
            @(posedge clk); #1;
        end
        i_last = 1'b0; i_multa = 16'd1; i_multb = 16'd3;
        @(negedge clk);
        chk("bp_nonlast_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_last = 1'b1; i_multa = 16'd2; i_multb = 16'd7;
        @(negedge clk);
        chk("bp_last_still_blocked", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        i_acc_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0; i_acc_ready = 1'b0;
        chk("bp_drained_count", 64'(res_q.size()), 64'd1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("bp_drained_acc", 64'(r.acc), 64'd15);
        end
        wait_valid("bp_second_valid");
        chk("bp_second_acc", 64'(o_acc), 64'd17);
        chk("bp_second_cnt", 64'(o_acc_cnt), 64'd2);
        @(posedge clk); #1;
        i_acc_ready = 1'b1;
        wait_result(r, ok);
        if (ok) chk("bp_second_pop", 64'(r.acc), 64'd17);

        // Overflow: 600 signed 0x7FFF^2 terms cross 2^39 and saturate the count.
        for (int i = 0; i < 600; i++)
            issue(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, (i == 599) ? 1'b1 : 1'b0, ac);
        wait_result(r, ok);
        if (ok) begin
            chk("ovf_acc", 64'(r.acc), 64'(40'(64'd600 * 64'h3FFF0001)));
            chk("ovf_cnt", 64'(r.cnt), 64'd255);
            chk("ovf_flag", 64'(r.ovf), 64'd1);
        end

        // Reset with two terms in flight discards them.
        issue(1'b0, 1'b0, 16'd9, 16'd9, 1'b0, ac);
        issue(1'b0, 1'b0, 16'd4, 16'd4, 1'b0, ac);
        rstn = 1'b0; i_valid = 1'b1; i_last = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1; i_valid = 1'b0; i_last = 1'b0;
        chk("midrst_acc", 64'(o_acc), 64'd0);
        chk("midrst_mult", 64'({o_multa, o_multb}), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", 64'(res_q.size()), 64'd0);
        chk("midrst_valid", 64'(o_acc_valid), 64'd0);
        issue(1'b0, 1'b0, 16'd2, 16'd3, 1'b1, ac);
        wait_result(r, ok);
        if (ok) begin
            chk("post_rst_acc", 64'(r.acc), 64'd6);
            chk("post_rst_cnt", 64'(r.cnt), 64'd1);
            chk("post_rst_ovf", 64'(r.ovf), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
